// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        StInitWait,
        StSetup,
        StPulse,
        StHold,
        StWait,
        StIdle
    } lcd_state_e;

    // Bit positions inside the packed io_lcd word.
    localparam int unsigned LcdOnBit = 31;
    localparam int unsigned LcdEnBit = 10;
    localparam int unsigned LcdRsBit = 9;
    localparam int unsigned LcdRwBit = 8;

    localparam int unsigned InitLen = 4;
    localparam logic [7:0] InitRom [InitLen] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    localparam logic [7:0] CmdClear   = 8'h01;
    localparam logic [7:0] CmdHome    = 8'h02;
    localparam logic [7:0] CmdHomeAlt = 8'h03;

    // Clear and Return Home need the long execution wait.
    function automatic logic is_clear_class(logic rs, logic [7:0] data);
        return !rs && (data == CmdClear || data == CmdHome || data == CmdHomeAlt);
    endfunction

    function automatic int unsigned max2(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done pulses for one cycle on the last cycle of a loaded interval.
module lcd_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             done
);

    localparam logic [Width-1:0] One = Width'(1);

    logic [Width-1:0] cnt_q;
    logic             running_q;

    // No reset port: the owner loads the timer while it is held in reset.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt_q     <= load_val - One;
            running_q <= 1'b1;
        end else begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - One;
            end
            if (done) begin
                running_q <= 1'b0;
            end
        end
    end

    assign done = running_q && (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Character LCD sequencer: power-on init, then byte writes over valid/ready with
// counter-based setup / enable / hold / execution timing.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned PULSE_CYC   = 25,
    parameter int unsigned HOLD_CYC    = 25,
    parameter int unsigned EXEC_CYC    = 2500,
    parameter int unsigned CLEAR_CYC   = 100000,
    parameter int unsigned POWERUP_CYC = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_rs_i,
    input  logic [7:0]  req_data_i,
    output logic        req_ready_o,
    output logic        init_done_o,
    output logic        busy_o,
    output logic [31:0] io_lcd_o
);

    localparam int unsigned MaxCyc = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC,
                                          EXEC_CYC)), max2(CLEAR_CYC, POWERUP_CYC));
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    if (SETUP_CYC == 0 || PULSE_CYC == 0 || HOLD_CYC == 0 || EXEC_CYC == 0 ||
        CLEAR_CYC == 0 || POWERUP_CYC == 0) begin : g_param_check
        $error("lcd_ctrl: all timing parameters must be at least 1");
    end

    lcd_state_e state_q, state_d;
    logic [1:0] init_idx_q, init_idx_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       init_done_q, init_done_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       en_q, en_d;

    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic            tmr_done;

    lcd_timer #(
        .Width (CntW)
    ) u_timer (
        .clk      (clk_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        rs_d        = rs_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        tmr_load    = 1'b0;
        tmr_val     = CntW'(SETUP_CYC);

        unique case (state_q)
            StInitWait: begin
                if (tmr_done) begin
                    state_d  = StSetup;
                    rs_d     = 1'b0;
                    data_d   = InitRom[init_idx_q];
                    tmr_load = 1'b1;
                end
            end
            StSetup: begin
                if (tmr_done) begin
                    state_d  = StPulse;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(PULSE_CYC);
                end
            end
            StPulse: begin
                if (tmr_done) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = CntW'(HOLD_CYC);
                end
            end
            StHold: begin
                if (tmr_done) begin
                    state_d  = StWait;
                    tmr_load = 1'b1;
                    tmr_val  = is_clear_class(rs_q, data_q) ? CntW'(CLEAR_CYC)
                                                            : CntW'(EXEC_CYC);
                end
            end
            StWait: begin
                if (tmr_done) begin
                    if (init_done_q) begin
                        state_d = StIdle;
                    end else if (init_idx_q == 2'(InitLen - 1)) begin
                        state_d     = StIdle;
                        init_done_d = 1'b1;
                    end else begin
                        state_d    = StSetup;
                        init_idx_d = init_idx_q + 2'd1;
                        rs_d       = 1'b0;
                        data_d     = InitRom[init_idx_q + 2'd1];
                        tmr_load   = 1'b1;
                    end
                end
            end
            StIdle: begin
                if (req_valid_i) begin
                    state_d  = StSetup;
                    rs_d     = req_rs_i;
                    data_d   = req_data_i;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = StInitWait;
        endcase

        // Reset restarts the power-up wait from the first cycle after release.
        if (rst_i) begin
            tmr_load = 1'b1;
            tmr_val  = CntW'(POWERUP_CYC);
        end

        ready_d = (state_d == StIdle);
        busy_d  = !ready_d;
        en_d    = (state_d == StPulse);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StInitWait;
            init_idx_q  <= 2'd0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            en_q        <= en_d;
        end
    end

    always_comb begin
        io_lcd_o           = '0;
        io_lcd_o[LcdOnBit] = 1'b1;
        io_lcd_o[LcdEnBit] = en_q;
        io_lcd_o[LcdRsBit] = rs_q;
        io_lcd_o[LcdRwBit] = 1'b0;
        io_lcd_o[7:0]      = data_q;
    end

    assign req_ready_o = ready_q;
    assign init_done_o = init_done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: stimulus queues expected EN pulses, a monitor checks them.
module tb_lcd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rs = 1'b0;
    logic [7:0]  req_data = 8'h00;
    logic        req_ready;
    logic        init_done;
    logic        busy;
    logic [31:0] io_lcd;

    lcd_ctrl #(
        .SETUP_CYC   (2),
        .PULSE_CYC   (3),
        .HOLD_CYC    (2),
        .EXEC_CYC    (5),
        .CLEAR_CYC   (10),
        .POWERUP_CYC (20)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_rs_i    (req_rs),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .init_done_o (init_done),
        .busy_o      (busy),
        .io_lcd_o    (io_lcd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic skip_width = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] data, input int rise);
        exp_t e;
        e.rs   = rs;
        e.data = data;
        e.rise = rise;
        exp_q.push_back(e);
    endtask

    // Init pulses rise 2 setup cycles after each byte starts: bytes start at 20, 32, 44, 61.
    task automatic push_init(input int base);
        push_byte(1'b0, 8'h38, base + 22);
        push_byte(1'b0, 8'h0C, base + 34);
        push_byte(1'b0, 8'h01, base + 46);
        push_byte(1'b0, 8'h06, base + 63);
    endtask

    // Returns the first cycle with ready high and the first with init_done high.
    task automatic wait_ready(output int ready_cyc, output int done_cyc);
        ready_cyc = -1;
        done_cyc  = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (init_done && done_cyc < 0) done_cyc = cyc;
            if (req_ready) begin
                ready_cyc = cyc;
                break;
            end
        end
        if (ready_cyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got no ready, expected ready within 300 cycles");
        end
    endtask

    // Called at the negedge of a ready cycle; checks the return-to-ready latency.
    task automatic send(input logic rs, input logic [7:0] data, input int latency,
                        input string name);
        int acc, rc, dc;
        acc       = cyc;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = data;
        push_byte(rs, data, acc + 3);
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = 8'hEE;
        check({name, "_ready_drop"}, longint'(req_ready), 0);
        check({name, "_busy"}, longint'(busy), 1);
        check({name, "_setup_bus"}, longint'({io_lcd[10:8], io_lcd[7:0]}),
              longint'({2'b00, rs, 1'b0, data}));
        wait_ready(rc, dc);
        check({name, "_latency"}, longint'(rc - acc), longint'(latency));
    endtask

    // Monitor: every EN rising edge must match the head of the scoreboard.
    int   rise_cyc = 0;
    logic en_prev = 1'b0;
    always @(negedge clk) begin
        automatic logic en = io_lcd[10];
        if (en && !en_prev) begin
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got data 0x%0h at cycle %0d, expected none",
                         io_lcd[7:0], cyc);
            end else begin
                automatic exp_t e = exp_q.pop_front();
                check("pulse_cycle", longint'(cyc), longint'(e.rise));
                check("pulse_byte", longint'({io_lcd[9], io_lcd[7:0]}),
                      longint'({e.rs, e.data}));
            end
        end
        if (!en && en_prev) begin
            if (skip_width) skip_width = 1'b0;
            else check("pulse_width", longint'(cyc - rise_cyc), 3);
        end
        en_prev = en;
    end

    initial begin
        int base, rc, dc, p0;

        repeat (3) @(negedge clk);
        check("rst_io", longint'(io_lcd), 64'h8000_0000);
        check("rst_ready", longint'(req_ready), 0);
        check("rst_busy", longint'(busy), 1);
        check("rst_init_done", longint'(init_done), 0);

        rst  = 1'b0;
        base = cyc;
        push_init(base);
        wait_ready(rc, dc);
        check("init_ready_cycle", longint'(rc - base), 73);
        check("init_done_cycle", longint'(dc - base), 73);

        send(1'b1, 8'h41, 13, "data41");
        send(1'b0, 8'h01, 18, "clear");
        send(1'b0, 8'h80, 13, "ddram");
        send(1'b0, 8'h02, 18, "home");

        // Valid held high with fresh data every cycle: accepts land 13 cycles apart.
        p0 = cyc;
        for (int i = 0; i < 40; i++) begin
            req_valid = 1'b1;
            req_rs    = 1'b1;
            req_data  = 8'h50 + 8'(i);
            check("stream_ready", longint'(req_ready), longint'((i % 13) == 0));
            if ((i % 13) == 0) push_byte(1'b1, 8'h50 + 8'(i), cyc + 3);
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_ready(rc, dc);
        check("stream_ready_return", longint'(rc - p0), 52);

        // Reset while EN is high in the middle of a data pulse.
        p0        = cyc;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        push_byte(1'b1, 8'h5A, p0 + 3);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_pulse_en", longint'(io_lcd[10]), 1);
        skip_width = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        check("mid_rst_io", longint'(io_lcd), 64'h8000_0000);
        check("mid_rst_init_done", longint'(init_done), 0);
        check("mid_rst_ready", longint'(req_ready), 0);
        rst  = 1'b0;
        base = cyc;
        push_init(base);
        wait_ready(rc, dc);
        check("reinit_ready_cycle", longint'(rc - base), 73);
        check("reinit_done_cycle", longint'(dc - base), 73);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
